// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - counter encodings and reset/allocate values for the branch predictor
package bp_pkg;

  // 2-bit direction counter; MSB set means predict taken
  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } cnt_t;

  localparam cnt_t CNT_RESET        = WNT;
  localparam cnt_t CNT_ALLOC_BRANCH = WT;
  localparam cnt_t CNT_ALLOC_JUMP   = ST;

endpackage

// File: rtl/sat_cnt2.sv
// rtl/sat_cnt2.sv - next-state function of a 2-bit saturating direction counter
module sat_cnt2
  import bp_pkg::*;
(
  input  cnt_t cnt_cur,
  input  logic taken,
  output cnt_t cnt_nxt
);

  // step one toward the resolved direction, holding at SNT and ST
  always_comb begin
    cnt_nxt = cnt_cur;
    if (taken) begin
      if (cnt_cur != ST) cnt_nxt = cnt_t'(cnt_cur + 2'd1);
    end else begin
      if (cnt_cur != SNT) cnt_nxt = cnt_t'(cnt_cur - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB with 2-bit direction counters, mispredict detect and statistics
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_npc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_is_branch,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_npc,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            clr_stats,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int              IDX_W   = $clog2(ENTRIES);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [31:0]     CNT_MAX = 32'hFFFF_FFFF;

  // table state
  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [XLEN-1:0]   target_q [ENTRIES];
  cnt_t              cnt_q    [ENTRIES];

  logic [31:0] branch_cnt_q;
  logic [31:0] mispred_cnt_q;

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             upd_cf;
  logic [XLEN-1:0]  actual_npc;

  logic             tbl_we;
  logic             wr_valid;
  logic [TAG_W-1:0] wr_tag;
  logic [XLEN-1:0]  wr_target;
  cnt_t             wr_cnt;
  cnt_t             cnt_step;

  // upd_pred_taken is implied by upd_pred_npc; low PC bits and bits above the tag are not stored
  logic unused_bits;
  assign unused_bits = ^{upd_pred_taken, if_pc, upd_pc};

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_cf  = upd_is_branch | upd_is_jump;
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // fetch-side lookup straight from the registered table
  always_comb begin
    pred_hit   = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken = pred_hit && cnt_q[if_idx][1];
    pred_npc   = pred_taken ? target_q[if_idx] : if_pc + PC_STEP;
  end

  // mispredict compares the true next PC against what fetch actually used
  always_comb begin
    actual_npc  = upd_taken ? upd_target : upd_pc + PC_STEP;
    mispredict  = upd_valid && (actual_npc != upd_pred_npc);
    redirect_pc = actual_npc;
  end

  sat_cnt2 u_sat_cnt2 (
    .cnt_cur (cnt_q[upd_idx]),
    .taken   (upd_taken),
    .cnt_nxt (cnt_step)
  );

  // decide the new contents of the indexed entry for this resolved instruction
  always_comb begin
    tbl_we    = 1'b0;
    wr_valid  = valid_q[upd_idx];
    wr_tag    = tag_q[upd_idx];
    wr_target = target_q[upd_idx];
    wr_cnt    = cnt_q[upd_idx];
    if (upd_valid) begin
      if (upd_cf) begin
        if (upd_hit) begin
          tbl_we = 1'b1;
          if (upd_is_jump) begin
            wr_cnt    = ST;
            wr_target = upd_target;
          end else begin
            wr_cnt = cnt_step;
            if (upd_taken) wr_target = upd_target;
          end
        end else if (upd_taken) begin
          tbl_we    = 1'b1;
          wr_valid  = 1'b1;
          wr_tag    = upd_tag;
          wr_target = upd_target;
          wr_cnt    = upd_is_jump ? CNT_ALLOC_JUMP : CNT_ALLOC_BRANCH;
        end
      end else if (upd_hit) begin
        // a non-control-flow instruction aliased onto an entry: drop it
        tbl_we   = 1'b1;
        wr_valid = 1'b0;
      end
    end
  end

  // table registers, cleared asynchronously entry by entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_RESET;
      end
    end else if (tbl_we) begin
      valid_q[upd_idx]  <= wr_valid;
      tag_q[upd_idx]    <= wr_tag;
      target_q[upd_idx] <= wr_target;
      cnt_q[upd_idx]    <= wr_cnt;
    end
  end

  // saturating statistics; clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (clr_stats) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (upd_valid && upd_cf && (branch_cnt_q != CNT_MAX))
        branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict && (mispred_cnt_q != CNT_MAX))
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - table-driven scoreboard bench for branch_predictor
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_npc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_branch;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_npc;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        clr_stats;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  branch_predictor #(.XLEN(32), .ENTRIES(16), .TAG_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .if_pc          (if_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_npc       (pred_npc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_is_branch  (upd_is_branch),
    .upd_is_jump    (upd_is_jump),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .upd_pred_npc   (upd_pred_npc),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .clr_stats      (clr_stats),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] if_pc;
    logic        uv;
    logic [31:0] upc;
    logic        br;
    logic        jmp;
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] pnpc;
    logic        clr;
    logic        e_hit;
    logic        e_tk;
    logic [31:0] e_npc;
    logic        e_mp;
    logic [31:0] e_redir;
  } vec_t;

  typedef struct {
    logic        hit;
    logic        tk;
    logic [31:0] npc;
    logic        uv;
    logic        mp;
    logic [31:0] redir;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          n_chk;
  int          n_fail;
  logic [31:0] m_b;
  logic [31:0] m_m;

  function automatic vec_t mkv(input logic [31:0] ipc, input logic uv, input logic [31:0] upc,
                               input logic br, input logic jmp, input logic tk,
                               input logic [31:0] tgt, input logic [31:0] pnpc, input logic clr,
                               input logic e_hit, input logic e_tk, input logic [31:0] e_npc,
                               input logic e_mp, input logic [31:0] e_redir);
    vec_t v;
    v.if_pc = ipc; v.uv = uv; v.upc = upc; v.br = br; v.jmp = jmp; v.tk = tk;
    v.tgt = tgt; v.pnpc = pnpc; v.clr = clr;
    v.e_hit = e_hit; v.e_tk = e_tk; v.e_npc = e_npc; v.e_mp = e_mp; v.e_redir = e_redir;
    return v;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] x, input logic inc);
    if (inc && x != 32'hFFFF_FFFF) return x + 32'd1;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    if_pc          = v.if_pc;
    upd_valid      = v.uv;
    upd_pc         = v.upc;
    upd_is_branch  = v.br;
    upd_is_jump    = v.jmp;
    upd_taken      = v.tk;
    upd_target     = v.tgt;
    upd_pred_npc   = v.pnpc;
    upd_pred_taken = (v.pnpc != v.upc + 32'd4);
    clr_stats      = v.clr;
    e.hit = v.e_hit; e.tk = v.e_tk; e.npc = v.e_npc;
    e.uv = v.uv; e.mp = v.e_mp; e.redir = v.e_redir;
    sb.push_back(e);
  endtask

  task automatic check_comb(input int idx);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL sb_empty[%0d]: got 0 entries expected 1", idx);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("pred_hit[%0d]", idx), {31'd0, pred_hit}, {31'd0, e.hit});
    chk($sformatf("pred_taken[%0d]", idx), {31'd0, pred_taken}, {31'd0, e.tk});
    chk($sformatf("pred_npc[%0d]", idx), pred_npc, e.npc);
    chk($sformatf("mispredict[%0d]", idx), {31'd0, mispredict}, {31'd0, e.mp});
    if (e.uv) chk($sformatf("redirect_pc[%0d]", idx), redirect_pc, e.redir);
  endtask

  // one full cycle: drive at negedge, check lookup, clock, then check statistics
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    #1;
    check_comb(idx);
    @(posedge clk);
    if (v.clr) begin
      m_b = '0;
      m_m = '0;
    end else begin
      m_b = sat_inc(m_b, v.uv & (v.br | v.jmp));
      m_m = sat_inc(m_m, v.e_mp);
    end
    #1;
    chk($sformatf("branch_cnt[%0d]", idx), branch_cnt, m_b);
    chk($sformatf("mispred_cnt[%0d]", idx), mispred_cnt, m_m);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; m_b = '0; m_m = '0;
    reset = 1'b1;
    drive(mkv(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0));
    void'(sb.pop_front());
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hit", {31'd0, pred_hit}, 32'd0);
    chk("rst_npc", pred_npc, 32'h104);
    chk("rst_branch_cnt", branch_cnt, 32'd0);
    chk("rst_mispred_cnt", mispred_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    //              if_pc         uv upc           br jmp tk tgt      pnpc     clr hit tk npc       mp redir
    vecs.push_back(mkv(32'h100,      0, 32'h0,      0, 0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h104, 0, 32'h0));
    vecs.push_back(mkv(32'h100,      1, 32'h100,    1, 0, 1, 32'h80,  32'h104, 0, 0, 0, 32'h104, 1, 32'h80));
    vecs.push_back(mkv(32'h100,      0, 32'h0,      0, 0, 0, 32'h0,   32'h0,   0, 1, 1, 32'h80,  0, 32'h0));
    vecs.push_back(mkv(32'h100,      1, 32'h100,    1, 0, 0, 32'h0,   32'h80,  0, 1, 1, 32'h80,  1, 32'h104));
    vecs.push_back(mkv(32'h100,      1, 32'h100,    1, 0, 0, 32'h0,   32'h104, 0, 1, 0, 32'h104, 0, 32'h104));
    vecs.push_back(mkv(32'h100,      0, 32'h0,      0, 0, 0, 32'h0,   32'h0,   0, 1, 0, 32'h104, 0, 32'h0));
    vecs.push_back(mkv(32'h100,      1, 32'h100,    1, 0, 1, 32'h80,  32'h104, 0, 1, 0, 32'h104, 1, 32'h80));
    vecs.push_back(mkv(32'h100,      1, 32'h100,    1, 0, 1, 32'h90,  32'h104, 0, 1, 0, 32'h104, 1, 32'h90));
    vecs.push_back(mkv(32'h100,      0, 32'h0,      0, 0, 0, 32'h0,   32'h0,   0, 1, 1, 32'h90,  0, 32'h0));
    vecs.push_back(mkv(32'h140,      0, 32'h0,      0, 0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h144, 0, 32'h0));
    vecs.push_back(mkv(32'h140,      1, 32'h140,    0, 1, 1, 32'h200, 32'h144, 0, 0, 0, 32'h144, 1, 32'h200));
    vecs.push_back(mkv(32'h100,      0, 32'h0,      0, 0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h104, 0, 32'h0));
    vecs.push_back(mkv(32'h140,      0, 32'h0,      0, 0, 0, 32'h0,   32'h0,   0, 1, 1, 32'h200, 0, 32'h0));
    vecs.push_back(mkv(32'h140,      1, 32'h140,    0, 0, 0, 32'h0,   32'h200, 0, 1, 1, 32'h200, 1, 32'h144));
    vecs.push_back(mkv(32'h140,      0, 32'h0,      0, 0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h144, 0, 32'h0));
    vecs.push_back(mkv(32'h308,      1, 32'h308,    1, 0, 0, 32'h0,   32'h30C, 0, 0, 0, 32'h30C, 0, 32'h30C));
    vecs.push_back(mkv(32'h308,      0, 32'h0,      0, 0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h30C, 0, 32'h0));
    vecs.push_back(mkv(32'h308,      1, 32'h308,    0, 1, 1, 32'h400, 32'h30C, 0, 0, 0, 32'h30C, 1, 32'h400));
    vecs.push_back(mkv(32'h308,      1, 32'h308,    0, 1, 1, 32'h500, 32'h400, 0, 1, 1, 32'h400, 1, 32'h500));
    vecs.push_back(mkv(32'h308,      0, 32'h0,      0, 0, 0, 32'h0,   32'h0,   0, 1, 1, 32'h500, 0, 32'h0));
    vecs.push_back(mkv(32'h308,      1, 32'h308,    0, 1, 1, 32'h500, 32'h500, 0, 1, 1, 32'h500, 0, 32'h500));
    vecs.push_back(mkv(32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1, 0, 0, 32'h0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mkv(32'h308,      1, 32'h308,    1, 0, 1, 32'h500, 32'h30C, 1, 1, 1, 32'h500, 1, 32'h500));
    vecs.push_back(mkv(32'h308,      0, 32'h0,      0, 0, 0, 32'h0,   32'h0,   0, 1, 1, 32'h500, 0, 32'h0));

    foreach (vecs[i]) run_vec(vecs[i], i);

    // mid-stream asynchronous reset
    run_vec(mkv(32'h308, 1, 32'h308, 1, 0, 1, 32'h500, 32'h30C, 0, 1, 1, 32'h500, 1, 32'h500), 100);
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    chk("pre_rst_hit", {31'd0, pred_hit}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_hit", {31'd0, pred_hit}, 32'd0);
    chk("async_rst_taken", {31'd0, pred_taken}, 32'd0);
    chk("async_rst_npc", pred_npc, 32'h30C);
    chk("async_rst_branch_cnt", branch_cnt, 32'd0);
    chk("async_rst_mispred_cnt", mispred_cnt, 32'd0);
    m_b = '0; m_m = '0;
    @(negedge clk);
    reset = 1'b0;
    run_vec(mkv(32'h308, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h30C, 0, 32'h0), 101);

    // statistics saturation and clear priority
    @(negedge clk);
    upd_valid = 1'b0;
    force dut.branch_cnt_q = 32'hFFFF_FFFE;
    force dut.mispred_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.branch_cnt_q;
    release dut.mispred_cnt_q;
    #1;
    chk("preload_branch_cnt", branch_cnt, 32'hFFFF_FFFE);
    chk("preload_mispred_cnt", mispred_cnt, 32'hFFFF_FFFE);
    m_b = 32'hFFFF_FFFE; m_m = 32'hFFFF_FFFE;
    run_vec(mkv(32'h408, 1, 32'h408, 1, 0, 1, 32'h600, 32'h40C, 0, 0, 0, 32'h40C, 1, 32'h600), 200);
    run_vec(mkv(32'h408, 1, 32'h408, 1, 0, 1, 32'h600, 32'h40C, 0, 1, 1, 32'h600, 1, 32'h600), 201);
    run_vec(mkv(32'h408, 1, 32'h408, 1, 0, 1, 32'h600, 32'h40C, 0, 1, 1, 32'h600, 1, 32'h600), 202);
    chk("sat_branch_cnt", branch_cnt, 32'hFFFF_FFFF);
    chk("sat_mispred_cnt", mispred_cnt, 32'hFFFF_FFFF);
    run_vec(mkv(32'h408, 1, 32'h408, 1, 0, 1, 32'h600, 32'h40C, 1, 1, 1, 32'h600, 1, 32'h600), 203);
    run_vec(mkv(32'h408, 1, 32'h408, 1, 0, 1, 32'h600, 32'h40C, 0, 1, 1, 32'h600, 1, 32'h600), 204);

    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
